// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC source encodings, opcode constants and fetch states.
// Imported by the fetch unit and its next-PC selector.
package cpu_pkg;

   localparam int OP_W = 4;

   typedef enum logic [1:0] {
      FONTE_ULA    = 2'b00,
      FONTE_ULAOUT = 2'b01,
      FONTE_JMP    = 2'b10,
      FONTE_RSVD   = 2'b11
   } fonte_e;

   localparam logic [OP_W-1:0] OP_JMP = 4'b1011;
   localparam logic [OP_W-1:0] OP_BEQ = 4'b1100;

   typedef enum logic [1:0] {
      ST_REQ   = 2'b00,
      ST_WAIT  = 2'b01,
      ST_READY = 2'b10
   } fetch_state_e;

   // Reload value so that the 15th WAIT cycle without Ack sees terminal count 0.
   localparam logic [3:0] WAIT_TC_LOAD = 4'd14;

   function automatic logic [OP_W-1:0] get_opcode(input logic [OP_W-1:0] top_bits);
      return top_bits;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Control and instruction-memory signals of the fetch unit.
// master = fetch unit side, slave = control/memory environment side.
interface fetch_unit_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16
);
   logic               EscCP;
   logic               EscCondCP;
   logic [1:0]         FonteCP;
   logic               Zero;
   logic [PC_W-1:0]    ULA_Res;
   logic [PC_W-1:0]    ULA_Out;
   logic               IMem_Ack;
   logic [INSTR_W-1:0] IMem_Data;
   logic               IMem_Req;
   logic [PC_W-1:0]    IMem_Addr;
   logic [PC_W-1:0]    PC;
   logic [INSTR_W-1:0] Instr;
   logic [3:0]         CodOP;
   logic               InstrValid;
`ifdef FETCH_TIMEOUT_EN
   logic               Fetch_Err;
`endif

   modport master (
      input  EscCP, EscCondCP, FonteCP, Zero, ULA_Res, ULA_Out,
      input  IMem_Ack, IMem_Data,
      output IMem_Req, IMem_Addr, PC, Instr, CodOP, InstrValid
`ifdef FETCH_TIMEOUT_EN
      , output Fetch_Err
`endif
   );

   modport slave (
      output EscCP, EscCondCP, FonteCP, Zero, ULA_Res, ULA_Out,
      output IMem_Ack, IMem_Data,
      input  IMem_Req, IMem_Addr, PC, Instr, CodOP, InstrValid
`ifdef FETCH_TIMEOUT_EN
      , input Fetch_Err
`endif
   );

endinterface

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC source mux and PC write-enable decode for the fetch unit.
// The reserved source select suppresses the write so the PC holds without a refetch.
module pc_next_sel
   import cpu_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic            i_ready,
   input  logic            i_esc_cp,
   input  logic            i_esc_cond_cp,
   input  logic            i_zero,
   input  logic [1:0]      i_fonte,
   input  logic [PC_W-1:0] i_ula_res,
   input  logic [PC_W-1:0] i_ula_out,
   input  logic [PC_W-1:0] i_jmp_field,
   input  logic [PC_W-1:0] i_pc,
   output logic            o_pc_we,
   output logic [PC_W-1:0] o_pc_next
);

   logic w_wr_req;
   logic w_src_ok;

   // EscCP dominates, so Zero only matters for a purely conditional write.
   assign w_wr_req = i_esc_cp | (i_esc_cond_cp & i_zero);

   always_comb begin
      o_pc_next = i_pc;
      w_src_ok  = 1'b1;
      case (fonte_e'(i_fonte))
         FONTE_ULA:    o_pc_next = i_ula_res;
         FONTE_ULAOUT: o_pc_next = i_ula_out;
         FONTE_JMP:    o_pc_next = i_jmp_field;
         default:      w_src_ok  = 1'b0;
      endcase
   end

   assign o_pc_we = i_ready & w_wr_req & w_src_ok;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, instruction register and REQ/WAIT/READY fetch FSM.
// Define FETCH_TIMEOUT_EN to add a WAIT timeout counter and sticky Fetch_Err output.
//
// state    | meaning
// ST_REQ   | request issued, moving to WAIT
// ST_WAIT  | request held until IMem_Ack loads Instr
// ST_READY | Instr valid for PC, waiting for a PC write
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16
) (
   input  logic         CLK,
   input  logic         RST_N,
   fetch_unit_if.master bus
);

   fetch_state_e       r_state;
   logic [PC_W-1:0]    r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic               r_req;
   logic               r_valid;
`ifdef FETCH_TIMEOUT_EN
   logic [3:0]         r_wait_cnt;
   logic               r_fetch_err;
`endif

   logic               w_pc_we;
   logic [PC_W-1:0]    w_pc_next;
   logic [PC_W-1:0]    w_jmp_field;
   logic               w_ready;

   assign w_jmp_field = r_instr[PC_W-1:0];
   assign w_ready     = (r_state == ST_READY);

   pc_next_sel #(
      .PC_W (PC_W)
   ) u_pc_next_sel (
      .i_ready       (w_ready),
      .i_esc_cp      (bus.EscCP),
      .i_esc_cond_cp (bus.EscCondCP),
      .i_zero        (bus.Zero),
      .i_fonte       (bus.FonteCP),
      .i_ula_res     (bus.ULA_Res),
      .i_ula_out     (bus.ULA_Out),
      .i_jmp_field   (w_jmp_field),
      .i_pc          (r_pc),
      .o_pc_we       (w_pc_we),
      .o_pc_next     (w_pc_next)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state     <= ST_REQ;
         r_pc        <= '0;
         r_instr     <= '0;
         r_req       <= 1'b0;
         r_valid     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         r_wait_cnt  <= WAIT_TC_LOAD;
         r_fetch_err <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_REQ: begin
               r_req   <= 1'b1;
               r_state <= ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
               r_wait_cnt <= WAIT_TC_LOAD;
`endif
            end
            ST_WAIT: begin
               if (bus.IMem_Ack) begin
                  r_instr <= bus.IMem_Data;
                  r_req   <= 1'b0;
                  r_valid <= 1'b1;
                  r_state <= ST_READY;
               end
`ifdef FETCH_TIMEOUT_EN
               // Timeout keeps the request line high and re-enters REQ to re-issue it.
               else if (r_wait_cnt == 4'd0) begin
                  r_fetch_err <= 1'b1;
                  r_state     <= ST_REQ;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 4'd1;
               end
`endif
            end
            ST_READY: begin
               if (w_pc_we) begin
                  r_pc    <= w_pc_next;
                  r_req   <= 1'b1;
                  r_valid <= 1'b0;
                  r_state <= ST_REQ;
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_valid <= 1'b0;
               r_state <= ST_REQ;
            end
         endcase
      end
   end

   assign bus.PC         = r_pc;
   assign bus.IMem_Addr  = r_pc;
   assign bus.IMem_Req   = r_req;
   assign bus.Instr      = r_instr;
   assign bus.CodOP      = get_opcode(r_instr[INSTR_W-1 -: OP_W]);
   assign bus.InstrValid = r_valid;
`ifdef FETCH_TIMEOUT_EN
   assign bus.Fetch_Err  = r_fetch_err;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized PC writes
// checked against a rule-level model of PC, Instr and InstrValid.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   logic [PC_W-1:0]    m_pc;
   logic [INSTR_W-1:0] m_instr;
   logic               m_valid;

   fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

   fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.EscCP     = 1'b0;
      bus.EscCondCP = 1'b0;
      bus.FonteCP   = 2'b00;
      bus.Zero      = 1'b0;
      bus.ULA_Res   = '0;
      bus.ULA_Out   = '0;
      bus.IMem_Ack  = 1'b0;
      bus.IMem_Data = '0;
   endtask

   task automatic chk_ready(input string tag);
      chk({tag, ".pc"},    32'(bus.PC),         32'(m_pc));
      chk({tag, ".instr"}, 32'(bus.Instr),      32'(m_instr));
      chk({tag, ".op"},    32'(bus.CodOP),      32'(m_instr[INSTR_W-1:INSTR_W-4]));
      chk({tag, ".valid"}, 32'(bus.InstrValid), 32'(1));
      chk({tag, ".req"},   32'(bus.IMem_Req),   32'(0));
   endtask

   task automatic rand_noise_write();
      bus.EscCP     = 1'($urandom_range(0, 1));
      bus.EscCondCP = 1'($urandom_range(0, 1));
      bus.Zero      = 1'($urandom_range(0, 1));
      bus.FonteCP   = 2'($urandom_range(0, 3));
      bus.ULA_Res   = PC_W'($urandom);
      bus.ULA_Out   = PC_W'($urandom);
   endtask

   // Drives a PC-write request from READY and checks the outcome against the rules.
   task automatic do_write(input string tag, input logic esc, input logic cond, input logic zero,
                           input logic [1:0] fonte, input logic [PC_W-1:0] res,
                           input logic [PC_W-1:0] out, input logic stray_ack, output logic taken);
      logic [PC_W-1:0] nxt;
      taken = (esc || (cond && zero)) && (fonte != 2'b11);
      case (fonte)
         2'b00:   nxt = res;
         2'b01:   nxt = out;
         2'b10:   nxt = m_instr[PC_W-1:0];
         default: nxt = m_pc;
      endcase
      bus.EscCP     = esc;
      bus.EscCondCP = cond;
      bus.Zero      = zero;
      bus.FonteCP   = fonte;
      bus.ULA_Res   = res;
      bus.ULA_Out   = out;
      bus.IMem_Ack  = stray_ack;
      bus.IMem_Data = INSTR_W'($urandom);
      step();
      clear_inputs();
      if (taken) begin
         m_pc    = nxt;
         m_valid = 1'b0;
         chk({tag, ".pc"},    32'(bus.PC),         32'(m_pc));
         chk({tag, ".req"},   32'(bus.IMem_Req),   32'(1));
         chk({tag, ".addr"},  32'(bus.IMem_Addr),  32'(m_pc));
         chk({tag, ".valid"}, 32'(bus.InstrValid), 32'(0));
      end else begin
         chk_ready({tag, ".hold"});
      end
   endtask

   // Completes a fetch that was just started by a PC write; writes and Acks before WAIT are noise.
   task automatic fetch(input string tag, input logic [INSTR_W-1:0] data, input int nwait);
      rand_noise_write();
      bus.IMem_Ack  = 1'($urandom_range(0, 1));
      bus.IMem_Data = INSTR_W'($urandom);
      step();
      clear_inputs();
      chk({tag, ".w.pc"},    32'(bus.PC),         32'(m_pc));
      chk({tag, ".w.instr"}, 32'(bus.Instr),      32'(m_instr));
      chk({tag, ".w.req"},   32'(bus.IMem_Req),   32'(1));
      for (int i = 0; i < nwait; i++) begin
         rand_noise_write();
         step();
         clear_inputs();
         chk({tag, ".wait.pc"},    32'(bus.PC),         32'(m_pc));
         chk({tag, ".wait.valid"}, 32'(bus.InstrValid), 32'(0));
         chk({tag, ".wait.req"},   32'(bus.IMem_Req),   32'(1));
      end
      rand_noise_write();
      bus.IMem_Ack  = 1'b1;
      bus.IMem_Data = data;
      step();
      clear_inputs();
      m_instr = data;
      m_valid = 1'b1;
      chk_ready({tag, ".done"});
   endtask

   initial begin
      logic taken;
      n_vec   = 0;
      n_err   = 0;
      m_pc    = '0;
      m_instr = '0;
      m_valid = 1'b0;
      rst_n   = 1'b0;
      clear_inputs();
      rand_noise_write();
      @(negedge clk);

      // Reset, release and first fetch with two WAIT cycles
      step();
      step();
      chk("rst.pc",    32'(bus.PC),         32'(0));
      chk("rst.instr", 32'(bus.Instr),      32'(0));
      chk("rst.valid", 32'(bus.InstrValid), 32'(0));
      chk("rst.req",   32'(bus.IMem_Req),   32'(0));
`ifdef FETCH_TIMEOUT_EN
      chk("rst.err",   32'(bus.Fetch_Err),  32'(0));
`endif
      clear_inputs();
      rst_n = 1'b1;
      step();
      chk("rel.req",  32'(bus.IMem_Req),  32'(1));
      chk("rel.addr", 32'(bus.IMem_Addr), 32'(0));
      step();
      chk("rel.wait.req", 32'(bus.IMem_Req), 32'(1));
      bus.IMem_Ack  = 1'b1;
      bus.IMem_Data = 16'hB005;
      step();
      clear_inputs();
      m_instr = 16'hB005;
      m_valid = 1'b1;
      chk_ready("first");
      chk("first.op_jmp", 32'(bus.CodOP), 32'(OP_JMP));

      // Jump through the instruction's low field
      do_write("jmp", 1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 8'h00, 1'b0, taken);
      chk("jmp.pc_abs", 32'(bus.PC), 32'h05);
      fetch("jmp.f", 16'hC040, 1);

      // Conditional write: not taken, then taken
      do_write("beq0", 1'b0, 1'b1, 1'b0, 2'b01, 8'h00, 8'h20, 1'b1, taken);
      chk("beq0.pc_abs", 32'(bus.PC), 32'h05);
      do_write("beq1", 1'b0, 1'b1, 1'b1, 2'b01, 8'h00, 8'h20, 1'b0, taken);
      chk("beq1.pc_abs", 32'(bus.PC), 32'h20);
      fetch("beq1.f", 16'h1234, 0);

      // Reserved source: no write, no refetch; EscCP overrides a false condition
      do_write("rsvd", 1'b1, 1'b1, 1'b1, 2'b11, 8'h77, 8'h66, 1'b0, taken);
      do_write("both", 1'b1, 1'b1, 1'b0, 2'b00, 8'h21, 8'h99, 1'b0, taken);
      fetch("both.f", 16'h0042, 2);

      // PC wrap from all-ones to zero
      do_write("to_ff", 1'b1, 1'b0, 1'b0, 2'b01, 8'h00, 8'hFF, 1'b0, taken);
      fetch("to_ff.f", 16'h2000, 0);
      do_write("wrap", 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, taken);
      chk("wrap.addr_abs", 32'(bus.IMem_Addr), 32'h00);
      fetch("wrap.f", 16'h3001, 1);

      // Reset while WAIT with a simultaneous Ack
      do_write("pre_rst", 1'b1, 1'b0, 1'b0, 2'b00, 8'h33, 8'h00, 1'b0, taken);
      step();
      rst_n         = 1'b0;
      bus.IMem_Ack  = 1'b1;
      bus.IMem_Data = 16'hFFFF;
      step();
      clear_inputs();
      rst_n   = 1'b1;
      m_pc    = '0;
      m_instr = '0;
      m_valid = 1'b0;
      chk("wrst.instr", 32'(bus.Instr),      32'(0));
      chk("wrst.pc",    32'(bus.PC),         32'(0));
      chk("wrst.req",   32'(bus.IMem_Req),   32'(0));
      chk("wrst.valid", 32'(bus.InstrValid), 32'(0));
      step();
      chk("wrst.req2", 32'(bus.IMem_Req),  32'(1));
      chk("wrst.addr", 32'(bus.IMem_Addr), 32'(0));
      bus.IMem_Ack  = 1'b1;
      bus.IMem_Data = 16'hA55A;
      step();
      clear_inputs();
      m_instr = 16'hA55A;
      m_valid = 1'b1;
      chk_ready("wrst.f");

`ifdef FETCH_TIMEOUT_EN
      // WAIT timeout: 14 silent cycles are fine, the 15th flags and re-requests
      do_write("to", 1'b1, 1'b0, 1'b0, 2'b00, 8'h44, 8'h00, 1'b0, taken);
      step();
      for (int i = 0; i < 14; i++) step();
      chk("to.err14", 32'(bus.Fetch_Err), 32'(0));
      chk("to.req14", 32'(bus.IMem_Req),  32'(1));
      step();
      chk("to.err15", 32'(bus.Fetch_Err), 32'(1));
      chk("to.req15", 32'(bus.IMem_Req),  32'(1));
      chk("to.addr",  32'(bus.IMem_Addr), 32'h44);
      step();
      bus.IMem_Ack  = 1'b1;
      bus.IMem_Data = 16'h5150;
      step();
      clear_inputs();
      m_instr = 16'h5150;
      m_valid = 1'b1;
      chk_ready("to.f");
      chk("to.err_sticky", 32'(bus.Fetch_Err), 32'(1));
`endif

      // Randomized PC writes from READY, each taken write followed by a fetch
      for (int it = 0; it < 60; it++) begin
         do_write("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  PC_W'($urandom), PC_W'($urandom), 1'($urandom_range(0, 1)), taken);
         if (taken) fetch("rnd.f", INSTR_W'($urandom), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, PC and instruction-memory address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width; opcode is Instr[INSTR_W-1:INSTR_W-4].
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 EscCP  input  1  unconditional PC write, from control.
REQ-006 EscCondCP  input  1  conditional PC write, taken only when Zero=1.
REQ-007 FonteCP  input  2  PC source select: 00 ULA_Res, 01 ULA_Out, 10 jump field Instr[PC_W-1:0], 11 reserved.
REQ-008 Zero  input  1  ALU zero flag.
REQ-009 ULA_Res  input  PC_W  combinational ALU result, used for PC+1.
REQ-010 ULA_Out  input  PC_W  registered ALU result, used as branch target.
REQ-011 IMem_Ack  input  1  instruction memory data valid, one-cycle pulse.
REQ-012 IMem_Data  input  INSTR_W  instruction word, valid with IMem_Ack.
REQ-013 IMem_Req  output  1  fetch request, level.
REQ-014 IMem_Addr  output  PC_W  fetch address, equal to PC.
REQ-015 PC  output  PC_W  current program counter.
REQ-016 Instr  output  INSTR_W  instruction register.
REQ-017 CodOP  output  4  opcode field of Instr, to control.
REQ-018 InstrValid  output  1  Instr holds the instruction at PC.

Function
REQ-019 SHALL implement FSM states REQ, WAIT, READY.
REQ-020 REQ: IMem_Req=1 and move to WAIT in the next cycle.
REQ-021 WAIT: IMem_Req=1; when IMem_Ack=1, load Instr from IMem_Data in that edge and move to READY.
REQ-022 READY: IMem_Req=0 and InstrValid=1; Instr and PC are held.
REQ-023 PC write occurs when in READY and (EscCP=1 or (EscCondCP=1 and Zero=1)); the state then moves to REQ and InstrValid drops the next cycle.
REQ-024 Next PC: FonteCP 00 gives ULA_Res, 01 gives ULA_Out, 10 gives Instr[PC_W-1:0], 11 holds PC with no refetch.
REQ-025 EscCP and EscCondCP both high: treated as EscCP, so Zero is ignored.
REQ-026 EscCondCP=1 with Zero=0: PC unchanged and state stays READY.
REQ-027 PC writes requested in REQ or WAIT SHALL be ignored.
REQ-028 IMem_Ack outside WAIT SHALL be ignored, with Instr unchanged.
REQ-029 PC arithmetic is modulo 2^PC_W; ULA_Res=all-ones+1 wraps to 0 with no flag.
REQ-030 Latency: a PC write leads to IMem_Req high the next cycle; an Ack with zero wait gives InstrValid 2 cycles after the write.

Reset
REQ-031 RST_N=0 at an edge SHALL set PC=0, Instr=0, InstrValid=0, IMem_Req=0, and state REQ.
REQ-032 Reset during WAIT SHALL drop the outstanding request; an Ack arriving in the reset cycle is discarded.
REQ-033 The first edge after RST_N returns high SHALL assert IMem_Req with IMem_Addr=0.

Configuration
REQ-034 Macro FETCH_TIMEOUT_EN, when defined, SHALL add a 4-bit WAIT counter and a sticky output Fetch_Err (1 bit).
REQ-035 With FETCH_TIMEOUT_EN, 15 cycles in WAIT without Ack SHALL set Fetch_Err=1 and return to REQ to re-issue the request.
REQ-036 With FETCH_TIMEOUT_EN, Fetch_Err SHALL be cleared only by reset.
REQ-037 Without FETCH_TIMEOUT_EN, there is no port and no counter, and WAIT waits indefinitely.

Structure
REQ-038 Shared package cpu_pkg SHALL hold the FonteCP encodings (FONTE_ULA, FONTE_ULAOUT, FONTE_JMP), the opcode constants OP_JMP=1011 and OP_BEQ=1100, and the fetch state enumeration.
REQ-039 Next-PC mux plus write-enable decode SHALL be sub-module pc_next_sel; the FSM and registers remain in fetch_unit.

Verification
REQ-040 Reset release, Ack after 2 WAIT cycles with Data=0xB005 -> IMem_Addr=0, Instr=0xB005, CodOP=1011, InstrValid=1.
REQ-041 READY, EscCP=1, FonteCP=10, Instr=0xB005 -> PC=0x05, IMem_Req=1 next cycle, InstrValid=0.
REQ-042 READY, EscCondCP=1, FonteCP=01, ULA_Out=0x20: Zero=0 -> PC unchanged, stays READY; Zero=1 -> PC=0x20, refetch.
REQ-043 PC=0xFF, EscCP=1, FonteCP=00, ULA_Res=0x00 -> PC=0x00, fetch from address 0.
REQ-044 RST_N=0 during WAIT while Ack=1 -> Instr=0, PC=0, IMem_Req=0; the following fetch uses address 0.
REQ-045 With FETCH_TIMEOUT_EN, no Ack for 15 WAIT cycles -> Fetch_Err=1, IMem_Req re-issued, Fetch_Err persists after a later Ack.
